// File: rtl/alu_operand_stage_pkg.sv
// Shared types and constants for the ALU operand stage.
package alu_operand_stage_pkg;

  // Default operand / immediate width.
  localparam int DATA_W_DEF = 32;

  // Forward-select encoding that picks the register-file value.
  localparam int SEL_REG = 0;

  // Skid-buffer occupancy states.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Forwarding select: register value for select 0 or any out-of-range
// select, otherwise forwarding bus (select - 1).
import alu_operand_stage_pkg::*;

module fwd_mux #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_FWD  = 2,
  parameter int SEL_W  = $clog2(N_FWD + 1)
) (
  input  logic [SEL_W-1:0]             sel,
  input  logic [DATA_W-1:0]            reg_val,
  input  logic [N_FWD-1:0][DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]            result
);

  // Priority-free select: at most one forwarding index can match sel.
  always_comb begin
    result = reg_val;
    for (int k = 0; k < N_FWD; k++) begin
      result = (sel == SEL_W'(k + 1)) ? fwd_data[k] : result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves forwarded operands and holds them in a
// two-entry skid buffer so in_ready never depends combinationally on out_ready.
import alu_operand_stage_pkg::*;

module alu_operand_stage #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_FWD  = 2,
  parameter int SEL_W  = $clog2(N_FWD + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            reg_a,
  input  logic [DATA_W-1:0]            reg_b,
  input  logic [DATA_W-1:0]            imm,
  input  logic                         alu_src,
  input  logic [SEL_W-1:0]             fwd_sel_a,
  input  logic [SEL_W-1:0]             fwd_sel_b,
  input  logic [N_FWD-1:0][DATA_W-1:0] fwd_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            op_a,
  output logic [DATA_W-1:0]            op_b,
  output logic [DATA_W-1:0]            store_data,
  output logic [1:0]                   occupancy
);

  state_t              state_r, state_nx;
  logic                in_ready_r, out_valid_r;
  logic [1:0]          occupancy_r;
  logic [DATA_W-1:0]   main_a_r, main_b_r, main_st_r;
  logic [DATA_W-1:0]   skid_a_r, skid_b_r, skid_st_r;
  logic [DATA_W-1:0]   res_a_s, rt_s, res_b_s;
  logic                accept_s;
  logic                load_main_in_s, load_main_skid_s, load_skid_s;

  fwd_mux #(.DATA_W(DATA_W), .N_FWD(N_FWD), .SEL_W(SEL_W)) u_mux_a (
    .sel      (fwd_sel_a),
    .reg_val  (reg_a),
    .fwd_data (fwd_data),
    .result   (res_a_s)
  );

  fwd_mux #(.DATA_W(DATA_W), .N_FWD(N_FWD), .SEL_W(SEL_W)) u_mux_rt (
    .sel      (fwd_sel_b),
    .reg_val  (reg_b),
    .fwd_data (fwd_data),
    .result   (rt_s)
  );

  assign res_b_s  = alu_src ? imm : rt_s;
  assign accept_s = in_valid & in_ready_r;

  // Next-state and data-movement decode; flush overrides everything.
  always_comb begin
    state_nx         = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_nx = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nx       = ST_ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_nx = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && out_ready) begin
            state_nx       = ST_ONE;
            load_main_in_s = 1'b1;
          end else if (accept_s) begin
            state_nx    = ST_FULL;
            load_skid_s = 1'b1;
          end else if (out_ready) begin
            state_nx = ST_EMPTY;
          end else begin
            state_nx = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_nx         = ST_ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_nx = ST_FULL;
          end
        end
        default: begin
          state_nx = ST_EMPTY;
        end
      endcase
    end
  end

  // State register plus registered handshake and occupancy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_nx;
      in_ready_r  <= (state_nx != ST_FULL);
      out_valid_r <= (state_nx != ST_EMPTY);
      occupancy_r <= (state_nx == ST_FULL) ? 2'd2 :
                     (state_nx == ST_ONE)  ? 2'd1 : 2'd0;
    end
  end

  // Operand storage: main entry drives the ALU, skid entry catches overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_a_r  <= '0;
      main_b_r  <= '0;
      main_st_r <= '0;
      skid_a_r  <= '0;
      skid_b_r  <= '0;
      skid_st_r <= '0;
    end else begin
      if (load_main_in_s) begin
        main_a_r  <= res_a_s;
        main_b_r  <= res_b_s;
        main_st_r <= rt_s;
      end else if (load_main_skid_s) begin
        main_a_r  <= skid_a_r;
        main_b_r  <= skid_b_r;
        main_st_r <= skid_st_r;
      end
      if (load_skid_s) begin
        skid_a_r  <= res_a_s;
        skid_b_r  <= res_b_s;
        skid_st_r <= rt_s;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign occupancy  = occupancy_r;
  assign op_a       = main_a_r;
  assign op_b       = main_b_r;
  assign store_data = main_st_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: operand-resolution table plus
// hand-written skid-buffer, flush and reset sequences.
module tb_alu_operand_stage;

  localparam int DW = 32;
  localparam int NF = 2;
  localparam int SW = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DW-1:0]      reg_a = '0, reg_b = '0, imm = '0;
  logic               alu_src = 1'b0;
  logic [SW-1:0]      fwd_sel_a = '0, fwd_sel_b = '0;
  logic [NF-1:0][DW-1:0] fwd_data = '0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [DW-1:0]      op_a, op_b, store_data;
  logic [1:0]         occupancy;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] ra, rb, im, f0, f1;
    logic        src;
    logic [1:0]  sa, sb;
    logic [31:0] ea, eb, es;
  } vec_t;

  vec_t vecs [6];

  alu_operand_stage #(.DATA_W(DW), .N_FWD(NF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .imm        (imm),
    .alu_src    (alu_src),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b),
    .fwd_data   (fwd_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .store_data (store_data),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    reg_a     = a;
    reg_b     = b;
    alu_src   = 1'b0;
    fwd_sel_a = 2'd0;
    fwd_sel_b = 2'd0;
  endtask

  initial begin
    //            ra            rb            im            f0            f1            src   sa    sb    ea            eb            es
    vecs[0] = '{32'd5,        32'd7,        32'd0,        32'd0,        32'd0,        1'b0, 2'd0, 2'd0, 32'd5,        32'd7,        32'd7};
    vecs[1] = '{32'd1,        32'd7,        32'hFFFFFFFC, 32'hA0,       32'h10,       1'b1, 2'd0, 2'd2, 32'd1,        32'hFFFFFFFC, 32'h10};
    vecs[2] = '{32'd9,        32'd8,        32'd0,        32'h22,       32'h10,       1'b0, 2'd3, 2'd1, 32'd9,        32'h22,       32'h22};
    vecs[3] = '{32'd2,        32'h44,       32'd0,        32'h33,       32'h10,       1'b0, 2'd1, 2'd3, 32'h33,       32'h44,       32'h44};
    vecs[4] = '{32'd2,        32'h77,       32'h66,       32'h33,       32'h55,       1'b1, 2'd2, 2'd0, 32'h55,       32'h66,       32'h77};
    vecs[5] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'h1,        32'h2,        1'b0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_op_a",      op_a,               32'd0);
    rst_n = 1'b1;
    step();

    // Operand resolution table, streaming with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid    = 1'b1;
      reg_a       = vecs[i].ra;
      reg_b       = vecs[i].rb;
      imm         = vecs[i].im;
      fwd_data[0] = vecs[i].f0;
      fwd_data[1] = vecs[i].f1;
      alu_src     = vecs[i].src;
      fwd_sel_a   = vecs[i].sa;
      fwd_sel_b   = vecs[i].sb;
      step();
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_op_a", i),  op_a,       vecs[i].ea);
      check($sformatf("vec%0d_op_b", i),  op_b,       vecs[i].eb);
      check($sformatf("vec%0d_store", i), store_data, vecs[i].es);
    end
    in_valid = 1'b0;
    step();
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill both entries, third bundle waits upstream
    out_ready = 1'b0;
    present(32'd1, 32'h101);
    step();
    check("bp1_occ", {30'd0, occupancy}, 32'd1);
    present(32'd2, 32'h102);
    step();
    check("bp2_occ",   {30'd0, occupancy}, 32'd2);
    check("bp2_ready", {31'd0, in_ready},  32'd0);
    present(32'd3, 32'h103);
    step();
    check("bp3_occ",   {30'd0, occupancy}, 32'd2);
    check("bp3_hold_a", op_a,              32'd1);
    check("bp3_hold_st", store_data,       32'h101);
    out_ready = 1'b1;
    step();
    check("drain1_valid", {31'd0, out_valid}, 32'd1);
    check("drain1_a",     op_a,               32'd2);
    check("drain1_ready", {31'd0, in_ready},  32'd1);
    step();
    check("drain2_valid", {31'd0, out_valid}, 32'd1);
    check("drain2_a",     op_a,               32'd3);
    check("drain2_st",    store_data,         32'h103);
    in_valid = 1'b0;
    step();
    check("drain3_empty", {31'd0, out_valid}, 32'd0);

    // Flush from FULL with a bundle presented in the flush cycle
    out_ready = 1'b0;
    present(32'h11, 32'd0);
    step();
    present(32'h12, 32'd0);
    step();
    check("fl_full", {30'd0, occupancy}, 32'd2);
    present(32'h13, 32'd0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_occ",   {30'd0, occupancy}, 32'd0);
    check("fl_ready", {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    step();
    check("fl_no_ghost", {31'd0, out_valid}, 32'd0);

    // Flush together with out_ready from ONE
    present(32'h21, 32'd0);
    step();
    check("fo_one", {30'd0, occupancy}, 32'd1);
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    check("fo_empty", {30'd0, occupancy}, 32'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    present(32'h31, 32'd0);
    step();
    present(32'h32, 32'd0);
    step();
    in_valid = 1'b0;
    check("ar_full", {30'd0, occupancy}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_ready", {31'd0, in_ready},  32'd1);
    check("ar_occ",   {30'd0, occupancy}, 32'd0);
    check("ar_op_a",  op_a,               32'd0);
    check("ar_op_b",  op_b,               32'd0);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    present(32'h99, 32'h98);
    step();
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_a",     op_a,               32'h99);
    check("post_rst_occ",   {30'd0, occupancy}, 32'd1);
    in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/immediate width in bits.
REQ-002 SHALL have parameter N_FWD, default 2, number of forwarding sources (1..7).
REQ-003 SHALL have parameter SEL_W, default $clog2(N_FWD+1), forward-select width.
REQ-004 SHALL have ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream operand bundle valid.
- in_ready  output  1  stage can accept a bundle.
- reg_a  input  DATA_W  register-file rs value.
- reg_b  input  DATA_W  register-file rt value.
- imm  input  DATA_W  sign-extended immediate.
- alu_src  input  1  0 = B from rt path, 1 = B from imm.
- fwd_sel_a  input  SEL_W  0 = reg_a, k = fwd_data[k-1].
- fwd_sel_b  input  SEL_W  0 = reg_b, k = fwd_data[k-1].
- fwd_data  input  N_FWD x DATA_W  forwarding buses (EX/MEM, MEM/WB, ...).
- flush  input  1  squash all held bundles.
- out_valid  output  1  op bundle valid.
- out_ready  input  1  ALU accepts bundle.
- op_a  output  DATA_W  ALU operand A.
- op_b  output  DATA_W  ALU operand B.
- store_data  output  DATA_W  forwarded rt value, independent of alu_src.
- occupancy  output  2  bundles held (0..2).

Function
REQ-005 SHALL resolve A = fwd_sel_a==0 ? reg_a : fwd_data[fwd_sel_a-1]; select > N_FWD SHALL fall back to reg_a.
REQ-006 SHALL resolve rt_fwd the same way from reg_b/fwd_sel_b; op_b = alu_src ? imm : rt_fwd; store_data = rt_fwd.
REQ-007 SHALL sample resolved values only on transfer (in_valid & in_ready); operands SHALL be registered, latency exactly 1 cycle from accept to out_valid with empty stage.
REQ-008 SHALL implement a 2-entry skid buffer: main register drives outputs; skid register captures a bundle accepted while main is valid and out_ready is low.
REQ-009 in_ready SHALL be a registered signal equal to "skid entry empty"; no combinational path out_ready -> in_ready.
REQ-010 States: EMPTY (occ 0), ONE (occ 1, main valid), FULL (occ 2, main+skid valid).
REQ-011 EMPTY: accept -> ONE.
REQ-012 ONE: accept & out_ready -> ONE (main replaced); accept & !out_ready -> FULL; !accept & out_ready -> EMPTY; else hold.
REQ-013 FULL: in_ready=0; out_ready -> ONE with skid moved to main; else hold.
REQ-014 out_valid and op_a/op_b/store_data SHALL be stable while out_valid & !out_ready.
REQ-015 Bundles SHALL leave in acceptance order; no loss, no duplication.
REQ-016 flush SHALL, next edge, clear all held bundles (state EMPTY, out_valid=0, in_ready=1); a bundle presented in the flush cycle SHALL be discarded.
REQ-017 Simultaneous flush and out_ready SHALL count the main bundle as consumed by ALU; nothing else advances.
REQ-018 occupancy SHALL equal the count of valid entries (0, 1, 2).

Reset
REQ-019 rst_n low SHALL asynchronously force EMPTY: out_valid=0, in_ready=1, occupancy=0, op_a=op_b=store_data=0, skid data=0.
REQ-020 Reset mid-transfer SHALL drop all held bundles; first accept after rst_n rises behaves as from EMPTY.

Structure
REQ-021 Shared package SHALL hold the state enum (EMPTY/ONE/FULL) and DATA_W default; fwd-select encoding constant SEL_REG=0 there too.
REQ-022 Forward-select mux SHALL be one sub-module fwd_mux (DATA_W, N_FWD), instantiated twice (A, rt).

Verification
REQ-023 Reset release, in_valid=1, reg_a=5, reg_b=7, alu_src=0, sels 0, out_ready=1 -> next cycle op_a=5, op_b=7, store_data=7, out_valid=1.
REQ-024 alu_src=1, imm=0xFFFF_FFFC, fwd_sel_b=2, fwd_data[1]=0x10 -> op_b=0xFFFF_FFFC, store_data=0x10.
REQ-025 fwd_sel_a=3 with N_FWD=2, reg_a=9 -> op_a=9.
REQ-026 Accept bundles 1,2,3 with out_ready=0 -> occupancy 2, in_ready=0, bundle 3 held upstream; raise out_ready -> outputs 1,2,3 in order, no gaps.
REQ-027 FULL, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, flushed-cycle bundle never appears.
REQ-028 Drop rst_n while occupancy=2 -> immediately out_valid=0, outputs 0, in_ready=1.
